// File: rtl/lu_recompose_pkg.sv
// Shared definitions for the LU decomposer and its recompose checker:
// FSM state encodings, matrix geometry and default data widths.
package lu_pkg;

    localparam int N_ELEM    = 9;
    localparam int N_DIM     = 3;
    localparam int DEF_IN_W  = 3;
    localparam int DEF_OUT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CAL    = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_SING   = 3'd4
    } lu_state_e;

endpackage

// File: rtl/lu_recompose_if.sv
// Stream interface between the LU result producer and the recompose checker.
// master drives the L/U stream and observes the product stream; slave is the checker.
interface lu_recompose_if
    import lu_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic                    in_valid;
    logic                    invertible;
    logic                    decomposable;
    logic signed [IN_W-1:0]  in_l;
    logic signed [IN_W-1:0]  in_u;
    logic                    busy;
    logic                    out_valid;
    logic                    out_singular;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_valid, invertible, decomposable, in_l, in_u,
        input  busy, out_valid, out_singular, out_data
    );

    modport slave (
        input  in_valid, invertible, decomposable, in_l, in_u,
        output busy, out_valid, out_singular, out_data
    );
endinterface

// File: rtl/lu_row_mac.sv
// Combinational 3-term signed dot product: one L row against one U column.
// Each product is formed at full precision, then sign-extended to OUT_W and
// summed; the result wraps silently if it exceeds OUT_W.
module lu_row_mac #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  a0,
    input  logic signed [IN_W-1:0]  a1,
    input  logic signed [IN_W-1:0]  a2,
    input  logic signed [IN_W-1:0]  b0,
    input  logic signed [IN_W-1:0]  b1,
    input  logic signed [IN_W-1:0]  b2,
    output logic signed [OUT_W-1:0] sum
);
    localparam int PW = 2 * IN_W;

    logic signed [PW-1:0] m0, m1, m2;

    assign m0  = PW'(a0) * PW'(b0);
    assign m1  = PW'(a1) * PW'(b1);
    assign m2  = PW'(a2) * PW'(b2);
    assign sum = OUT_W'(m0) + OUT_W'(m1) + OUT_W'(m2);
endmodule

// File: rtl/lu_recompose.sv
// Rebuilds P*A = L*U from the serial LU result stream and streams the
// 9 product entries back out row-major, or echoes a singular marker.
//
// state  | meaning
// IDLE   | waiting for element 0 or a singular marker
// LOAD   | capturing elements 1..8; a gap in in_valid aborts the stream
// CAL    | one product row per cycle, rows 0..2
// OUTPUT | presenting P[0..8], one entry per cycle
// SING   | presenting the singular marker for one cycle
module lu_recompose
    import lu_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    lu_recompose_if.slave bus
);
    lu_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic signed [IN_W-1:0]  l_reg [N_ELEM];
    logic signed [IN_W-1:0]  u_reg [N_ELEM];
    logic signed [OUT_W-1:0] p_reg [N_ELEM];

    logic signed [IN_W-1:0]  l_row   [N_DIM];
    logic signed [OUT_W-1:0] col_sum [N_DIM];
    logic [3:0] row_base;

    logic accept, store_en;
    logic [3:0] store_idx;

    logic busy_q, valid_q, sing_q;
    logic signed [OUT_W-1:0] data_q;
    logic busy_d, valid_d, sing_d;
    logic signed [OUT_W-1:0] data_d;

    assign accept    = bus.in_valid & bus.invertible & bus.decomposable;
    assign store_en  = ((state_q == ST_IDLE) & accept) | ((state_q == ST_LOAD) & bus.in_valid);
    assign store_idx = (state_q == ST_IDLE) ? 4'd0 : cnt_q;

    // State and counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                    cnt_d   = 4'd1;
                end else if (bus.in_valid) begin
                    state_d = ST_SING;
                    cnt_d   = 4'd0;
                end
            end
            ST_LOAD: begin
                if (!bus.in_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd8) begin
                    state_d = ST_CAL;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_CAL: begin
                if (cnt_q == 4'd2) begin
                    state_d = ST_OUTPUT;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_OUTPUT: begin
                if (cnt_q == 4'd8) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Next values of the registered outputs; entry 0 is preloaded on the last CAL cycle
    always_comb begin
        busy_d  = (state_d == ST_CAL) || (state_d == ST_OUTPUT) || (state_d == ST_SING);
        valid_d = 1'b0;
        sing_d  = 1'b0;
        data_d  = '0;
        if ((state_q == ST_IDLE) && bus.in_valid && !accept) begin
            valid_d = 1'b1;
            sing_d  = 1'b1;
        end else if ((state_q == ST_CAL) && (cnt_q == 4'd2)) begin
            valid_d = 1'b1;
            data_d  = p_reg[0];
        end else if ((state_q == ST_OUTPUT) && (cnt_q != 4'd8)) begin
            valid_d = 1'b1;
            data_d  = p_reg[cnt_q + 4'd1];
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            sing_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            sing_q  <= sing_d;
            data_q  <= data_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_singular = sing_q;
    assign bus.out_data     = data_q;

    // Select the L row for the current CAL cycle
    always_comb begin
        case (cnt_q[1:0])
            2'd0:    row_base = 4'd0;
            2'd1:    row_base = 4'd3;
            default: row_base = 4'd6;
        endcase
        for (int k = 0; k < N_DIM; k++) begin
            l_row[k] = l_reg[row_base + 4'(k)];
        end
    end

    for (genvar j = 0; j < N_DIM; j++) begin : g_col
        lu_row_mac #(.IN_W(IN_W), .OUT_W(OUT_W)) u_mac (
            .a0  (l_row[0]),
            .a1  (l_row[1]),
            .a2  (l_row[2]),
            .b0  (u_reg[j]),
            .b1  (u_reg[3 + j]),
            .b2  (u_reg[6 + j]),
            .sum (col_sum[j])
        );
    end

    // L/U capture and product row write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ELEM; i++) begin
                l_reg[i] <= '0;
                u_reg[i] <= '0;
                p_reg[i] <= '0;
            end
        end else begin
            if (store_en) begin
                l_reg[store_idx] <= bus.in_l;
                u_reg[store_idx] <= bus.in_u;
            end
            if (state_q == ST_CAL) begin
                for (int j = 0; j < N_DIM; j++) begin
                    p_reg[row_base + 4'(j)] <= col_sum[j];
                end
            end
        end
    end
endmodule
